// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Summary  : Parametrised pipeline-stage register with a valid/ready handshake.
//            A two-entry skid buffer gives full throughput, and ready is decoded
//            from registered state only. Also provides a synchronous flush,
//            an occupancy status output and a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occ_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_STALL_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [CNT_W-1:0] stall_q;

  logic accept;
  logic drain;
  logic stall_now;

  // Handshake status is decoded purely from registered state, so neither
  // ready nor valid has a combinational path from the stage inputs.
  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = (state_q != ST_FULL);
  assign out_data_o  = main_q;
  assign occ_o       = (state_q == ST_FULL) ? 2'd2 :
                       (state_q == ST_ONE)  ? 2'd1 : 2'd0;
  assign stall_cnt_o = stall_q;

  assign accept    = in_valid_i & in_ready_o;
  assign drain     = out_valid_o & out_ready_i;
  assign stall_now = out_valid_o & ~out_ready_i & ~flush_i;

  // Occupancy FSM with its payload registers; main always holds the oldest beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      // Squash drops held entries and any same-cycle beat; payload is left as-is.
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q <= ST_ONE;
            main_q  <= in_data_i;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_q <= in_data_i;
          end else if (accept) begin
            state_q <= ST_FULL;
            skid_q  <= in_data_i;
          end else if (drain) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Input is not ready here, so only a drain can move the state.
          if (drain) begin
            state_q <= ST_ONE;
            main_q  <= skid_q;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating count of cycles where downstream held off a valid beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (stall_now && (stall_q != C_STALL_MAX)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised pipeline-stage register, the successor to the fixed-field inter-stage latches. It carries an arbitrary-width payload with a valid/ready handshake instead of a bare enable, so stalls propagate backward without combinational ready paths. A two-entry skid buffer sustains full throughput. The stage also provides a synchronous flush for branch/exception squash, an occupancy status output and a saturating stall-cycle counter for performance debug.

Parameters:
WIDTH, 32, payload width in bits (>=1)
CNT_W, 16, stall counter width in bits (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
flush_i  in  1  synchronous squash of all held entries
in_valid_i  in  1  upstream beat valid
in_ready_o  out  1  stage can accept a beat this cycle
in_data_i  in  WIDTH  upstream payload
out_valid_o  out  1  main entry valid
out_ready_i  in  1  downstream accepts the main entry
out_data_o  out  WIDTH  main entry payload
occ_o  out  2  entries held: 0, 1 or 2
stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state EMPTY; main and skid data = 0; out_valid_o=0; in_ready_o=1; occ_o=0; stall_cnt_o=0. Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.
- Storage: main register (drives out_data_o directly) and skid register.
- States: EMPTY (occ 0), ONE (main valid), FULL (main and skid valid).
- Decoded outputs: out_valid_o = (state != EMPTY). in_ready_o = (state != FULL). Both are decoded from registered state only, so there is no combinational in->out path.
- Handshake definitions: accept = in_valid_i & in_ready_o. Drain = out_valid_o & out_ready_i.
- Transitions when flush_i=0:
  - EMPTY: accept -> ONE, main<=in_data_i. Otherwise stay in EMPTY.
  - ONE: accept & drain -> ONE, main<=in_data_i.
  - ONE: accept & !drain -> FULL, skid<=in_data_i.
  - ONE: !accept & drain -> EMPTY.
  - ONE: otherwise hold.
  - FULL: drain -> ONE, main<=skid. in_valid_i is ignored because in_ready_o=0.
  - FULL: otherwise hold.
- Flush: flush_i=1 at an edge forces the next state to EMPTY regardless of handshakes. A beat offered in the same cycle is dropped. The drain handshake still counts downstream, since the downstream side saw valid. Data registers keep their contents; out_data_o is don't-care while out_valid_o=0. The stall counter is not cleared.
- Latency: a beat accepted at edge N appears on out_data_o with out_valid_o=1 after edge N.
- Throughput: 1 beat/cycle sustained when out_ready_i is held high.
- Ordering: strict FIFO order is preserved; main is always older than skid.
- Payload rule: payload is never modified; data registers only change on the load conditions above.
- stall_cnt_o: +1 at each edge where out_valid_o=1 & out_ready_i=0 and flush_i=0. It holds at 2^CNT_W-1 with no wrap and clears only on reset.
- Invariant: state FULL is entered only from ONE. A beat is never overwritten or duplicated.

Test Plan:
1. Reset then stream: rst_i pulse; in_valid_i=1 with data 0x11, 0x22, 0x33 on consecutive cycles; out_ready_i=1 -> out_data_o shows 0x11, 0x22, 0x33 on the three cycles after each accept; occ_o stays at 1; in_ready_o stays 1.
2. Backpressure fill: out_ready_i=0; push 0xA0, then 0xA1 -> occ_o=2, in_ready_o=0. A further push of 0xA2 is not accepted. Raise out_ready_i -> outputs 0xA0 then 0xA1. 0xA2 is accepted once in_ready_o=1, with no loss or duplication.
3. Flush when FULL: hold state FULL with 0xB0/0xB1; assert flush_i for 1 cycle together with in_valid_i data 0xB2 -> next cycle occ_o=0, out_valid_o=0, in_ready_o=1. 0xB2 never appears on the output.
4. Stall counter: hold out_valid_o=1, out_ready_i=0 for 5 cycles -> stall_cnt_o=5. With CNT_W=2, hold 6 cycles -> stall_cnt_o saturates at 3.
5. Async reset mid-operation: FULL state, assert rst_i between clock edges -> out_valid_o=0, occ_o=0, out_data_o=0 immediately, before the next edge.
6. Random stimulus (WIDTH=8, 10k cycles): random in_valid_i, out_ready_i and 2% flush_i -> output sequence equals a scoreboard FIFO model with flushes applied; occ_o never exceeds 2.
